// File: rtl/divider_4bits.sv
// divider_4bits: sequential 4-bit unsigned restoring divider.
// One shift/trial-subtract per cycle; start/done handshake with a one-cycle
// done pulse. Optional macro DIVIDER_4BITS_DIV_ZERO_CHECK_EN short-circuits a
// zero divisor straight to DONE and reports it on div_by_zero.
module divider_4bits (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] A,
   input  logic [3:0] B,
   output logic [3:0] Q,
   output logic [3:0] R,
   output logic       done,
   output logic       busy,
   output logic       div_by_zero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] aq_q, aq_d;     // dividend shifting out, quotient bits shifting in
   logic [3:0] b_q, b_d;       // captured divisor
   logic [4:0] p_q, p_d;       // partial remainder, one bit wider than the divisor
   logic [1:0] cnt_q, cnt_d;   // iteration index 0..3
   logic [3:0] q_q, q_d;
   logic [3:0] r_q, r_d;
`ifdef DIVIDER_4BITS_DIV_ZERO_CHECK_EN
   logic       dz_q, dz_d;
`endif

   // Iteration datapath: shift in the next dividend bit and trial-subtract B
   logic [4:0] trial;
   logic [4:0] diff;
   logic [4:0] p_next;
   logic [3:0] aq_next;

   always_comb begin
      trial   = {p_q[3:0], aq_q[3]};
      // T - {0,B} as T + two's complement of the zero-extended divisor
      diff    = trial + {1'b1, ~b_q} + 5'd1;
      p_next  = diff[4] ? trial : diff;
      aq_next = {aq_q[2:0], ~diff[4]};
   end

   // Next-state and register-update logic for the IDLE/RUN/DONE sequence
   always_comb begin
      state_d = state_q;
      aq_d    = aq_q;
      b_d     = b_q;
      p_d     = p_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      r_d     = r_q;
`ifdef DIVIDER_4BITS_DIV_ZERO_CHECK_EN
      dz_d    = dz_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (state_q == DONE) begin
               state_d = IDLE;
            end
            if (start) begin
               aq_d    = A;
               b_d     = B;
               p_d     = 5'd0;
               cnt_d   = 2'd0;
               state_d = RUN;
`ifdef DIVIDER_4BITS_DIV_ZERO_CHECK_EN
               // Zero divisor: present the natural result immediately
               if (B == 4'd0) begin
                  state_d = DONE;
                  q_d     = 4'hF;
                  r_d     = A;
                  dz_d    = 1'b1;
               end
`endif
            end
         end
         RUN: begin
            aq_d  = aq_next;
            p_d   = p_next;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
               state_d = DONE;
               q_d     = aq_next;
               r_d     = p_next[3:0];
`ifdef DIVIDER_4BITS_DIV_ZERO_CHECK_EN
               dz_d    = 1'b0;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset discards any in-flight division
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         aq_q    <= 4'd0;
         b_q     <= 4'd0;
         p_q     <= 5'd0;
         cnt_q   <= 2'd0;
         q_q     <= 4'd0;
         r_q     <= 4'd0;
`ifdef DIVIDER_4BITS_DIV_ZERO_CHECK_EN
         dz_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         aq_q    <= aq_d;
         b_q     <= b_d;
         p_q     <= p_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         r_q     <= r_d;
`ifdef DIVIDER_4BITS_DIV_ZERO_CHECK_EN
         dz_q    <= dz_d;
`endif
      end
   end

   // Outputs decoded from state and held result registers
   always_comb begin
      Q    = q_q;
      R    = r_q;
      done = (state_q == DONE);
      busy = (state_q == RUN);
`ifdef DIVIDER_4BITS_DIV_ZERO_CHECK_EN
      div_by_zero = dz_q;
`else
      div_by_zero = 1'b0;
`endif
   end

endmodule

// File: tb/tb_divider_4bits.sv
// tb_divider_4bits: directed self-checking bench for divider_4bits.
module tb_divider_4bits;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] A, B;
   logic [3:0] Q, R;
   logic       done, busy, div_by_zero;

   int total = 0;
   int bad   = 0;

   divider_4bits dut (
      .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
      .Q(Q), .R(R), .done(done), .busy(busy), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   // Issue one division and observe it; inputs and samples on the falling edge.
   task automatic run_div(input logic [3:0] a, input logic [3:0] b,
                          output logic [3:0] q, output logic [3:0] r,
                          output logic dz, output int lat,
                          output int busy_cnt, output logic done_next);
      q = 4'bx; r = 4'bx; dz = 1'bx; lat = -1; busy_cnt = 0;
      @(negedge clk);
      A = a; B = b; start = 1'b1;
      @(posedge clk);
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         if (n == 1) begin
            start = 1'b0;
            A = ~a; B = ~b;
         end
         if (busy) busy_cnt++;
         if (done) begin
            lat = n; q = Q; r = R; dz = div_by_zero;
            break;
         end
      end
      @(negedge clk);
      done_next = done;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; A = 4'd0; B = 4'd0;
      repeat (3) @(negedge clk);
      total++; if ({Q, R, done, busy, div_by_zero} !== 11'd0) begin
         bad++; $display("FAIL reset_outputs got=%b want=%b", {Q, R, done, busy, div_by_zero}, 11'd0);
      end
      reset = 1'b0;
      @(negedge clk);
      total++; if ({done, busy} !== 2'b00) begin
         bad++; $display("FAIL reset_idle got=%b want=00", {done, busy});
      end
   endtask

   task automatic test_basic();
      logic [3:0] q, r; logic dz, dn; int lat, bc;
      run_div(4'd13, 4'd4, q, r, dz, lat, bc, dn);
      total++; if (lat != 5) begin bad++; $display("FAIL basic_latency got=%0d want=5", lat); end
      total++; if (bc != 4) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=4", bc); end
      total++; if (q !== 4'd3) begin bad++; $display("FAIL basic_q got=%0d want=3", q); end
      total++; if (r !== 4'd1) begin bad++; $display("FAIL basic_r got=%0d want=1", r); end
      total++; if (dz !== 1'b0) begin bad++; $display("FAIL basic_dz got=%b want=0", dz); end
      total++; if (dn !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b want=0", dn); end
   endtask

   task automatic test_directed();
      logic [3:0] av [3] = '{4'd3, 4'd15, 4'd0};
      logic [3:0] bv [3] = '{4'd7, 4'd1, 4'd9};
      logic [3:0] qv [3] = '{4'd0, 4'd15, 4'd0};
      logic [3:0] rv [3] = '{4'd3, 4'd0, 4'd0};
      logic [3:0] q, r; logic dz, dn; int lat, bc;
      for (int i = 0; i < 3; i++) begin
         run_div(av[i], bv[i], q, r, dz, lat, bc, dn);
         total++; if (q !== qv[i] || r !== rv[i] || lat != 5) begin
            bad++; $display("FAIL directed_%0d got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=5",
                            i, q, r, lat, qv[i], rv[i]);
         end
      end
   endtask

   task automatic test_div_zero();
      logic [3:0] q, r; logic dz, dn; int lat, bc;
      run_div(4'd9, 4'd0, q, r, dz, lat, bc, dn);
      total++; if (q !== 4'd15 || r !== 4'd9) begin
         bad++; $display("FAIL divzero_result got q=%0d r=%0d want q=15 r=9", q, r);
      end
`ifdef DIVIDER_4BITS_DIV_ZERO_CHECK_EN
      total++; if (lat != 1) begin bad++; $display("FAIL divzero_latency got=%0d want=1", lat); end
      total++; if (dz !== 1'b1) begin bad++; $display("FAIL divzero_flag got=%b want=1", dz); end
      run_div(4'd8, 4'd2, q, r, dz, lat, bc, dn);
      total++; if (q !== 4'd4 || r !== 4'd0 || dz !== 1'b0) begin
         bad++; $display("FAIL divzero_clear got q=%0d r=%0d dz=%b want q=4 r=0 dz=0", q, r, dz);
      end
`else
      total++; if (lat != 5) begin bad++; $display("FAIL divzero_latency got=%0d want=5", lat); end
      total++; if (dz !== 1'b0) begin bad++; $display("FAIL divzero_flag got=%b want=0", dz); end
`endif
   endtask

   task automatic test_back_to_back();
      int cur = 0, cyc = 0, last = 0;
      logic [3:0] ea, eb;
      @(negedge clk);
      ea = 4'd0; eb = 4'd1;
      A = ea; B = eb; start = 1'b1;
      while (cur < 240 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            total++; if (Q !== ea / eb || R !== ea % eb) begin
               bad++; $display("FAIL sweep_%0d_%0d got q=%0d r=%0d want q=%0d r=%0d",
                               ea, eb, Q, R, ea / eb, ea % eb);
            end
            total++; if ({4'd0, Q} * {4'd0, eb} + {4'd0, R} !== {4'd0, ea} || R >= eb) begin
               bad++; $display("FAIL sweep_invariant a=%0d b=%0d got q=%0d r=%0d", ea, eb, Q, R);
            end
            if (cur > 0) begin
               total++; if (cyc - last != 5) begin
                  bad++; $display("FAIL sweep_period got=%0d want=5", cyc - last);
               end
            end
            last = cyc;
            cur++;
            if (cur < 240) begin
               ea = 4'(cur / 15); eb = 4'(cur % 15 + 1);
               A = ea; B = eb;
            end else begin
               start = 1'b0;
            end
         end
      end
      total++; if (cur != 240) begin bad++; $display("FAIL sweep_count got=%0d want=240", cur); end
      start = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_ignore_start();
      int lat = -1;
      @(negedge clk);
      A = 4'd14; B = 4'd3; start = 1'b1;
      @(posedge clk);
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         start = (n == 1 || n == 2);
         A = 4'd1; B = 4'd1;
         if (done) begin lat = n; break; end
      end
      start = 1'b0;
      total++; if (lat != 5 || Q !== 4'd4 || R !== 4'd2) begin
         bad++; $display("FAIL ignore_start got lat=%0d q=%0d r=%0d want lat=5 q=4 r=2", lat, Q, R);
      end
      repeat (3) @(negedge clk);
      total++; if (Q !== 4'd4 || R !== 4'd2 || done !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL hold_result got q=%0d r=%0d done=%b busy=%b want q=4 r=2 done=0 busy=0",
                         Q, R, done, busy);
      end
   endtask

   task automatic test_reset_midrun();
      logic [3:0] q, r; logic dz, dn; int lat, bc;
      int seen = 0;
      @(negedge clk);
      A = 4'd11; B = 4'd2; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      total++; if ({busy, done, Q, R} !== 10'd0) begin
         bad++; $display("FAIL reset_midrun got=%b want=%b", {busy, done, Q, R}, 10'd0);
      end
      repeat (8) begin
         @(negedge clk);
         if (done) seen++;
      end
      total++; if (seen != 0) begin bad++; $display("FAIL reset_no_done got=%0d want=0", seen); end
      run_div(4'd11, 4'd2, q, r, dz, lat, bc, dn);
      total++; if (q !== 4'd5 || r !== 4'd1 || lat != 5) begin
         bad++; $display("FAIL reset_rerun got q=%0d r=%0d lat=%0d want q=5 r=1 lat=5", q, r, lat);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_directed();
      test_div_zero();
      test_back_to_back();
      test_ignore_start();
      test_reset_midrun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
